sd_drive_arbiter: RTL and testbench

// - Multi-drive block-device request arbiter between emulated disk controllers (HDD/floppy) and the hps_io sd_* port.
// - Latches per-drive read/write request pulses and tracks mount/readonly state per drive.
// - Grants one transfer at a time, round-robin, to hps_io (VDNUM = NUM_DRIVES).
// - Stalls the CPU while any request is pending or in flight; reports completion and error per drive.

---
 rtl/sd_arb_pkg.sv | 13 +
 rtl/sd_drive_arbiter_if.sv | 13 +
 rtl/rr_arbiter.sv | 25 ++
 rtl/sd_drive_arbiter.sv | 154 +++++++++++++++
 tb/tb_sd_drive_arbiter.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/sd_arb_pkg.sv
// rtl/sd_arb_pkg.sv - shared types and helpers for the sd drive arbiter
package sd_arb_pkg;

  typedef enum logic [1:0] {IDLE, REQ, XFER} sd_arb_state_t;

  localparam int MAX_DRIVES = 4;

  // Index width for n drives, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sd_drive_arbiter_if.sv
// rtl/sd_drive_arbiter_if.sv - hps_io sd_* request/acknowledge bundle
interface sd_drive_arbiter_if #(
  parameter int NUM_DRIVES = 2,
  parameter int LBA_W      = 32
);
  logic [NUM_DRIVES-1:0]       sd_rd;
  logic [NUM_DRIVES-1:0]       sd_wr;
  logic [NUM_DRIVES*LBA_W-1:0] sd_lba;
  logic [NUM_DRIVES-1:0]       sd_ack;

  modport master (output sd_rd, output sd_wr, output sd_lba, input sd_ack);
  modport slave  (input sd_rd, input sd_wr, input sd_lba, output sd_ack);
endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick: first request at or after ptr
module rr_arbiter
  import sd_arb_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]         req,
  input  logic [idx_w(N)-1:0]  ptr,
  output logic [idx_w(N)-1:0]  gnt_idx,
  output logic                 gnt_valid
);
  localparam int W = idx_w(N);

  always_comb begin
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!gnt_valid && req[(int'(ptr) + k) % N]) begin
        gnt_valid = 1'b1;
        gnt_idx   = W'((int'(ptr) + k) % N);
      end
    end
  end

endmodule

// File: rtl/sd_drive_arbiter.sv
// rtl/sd_drive_arbiter.sv - round-robin arbiter of per-drive block requests onto hps_io sd_*
module sd_drive_arbiter
  import sd_arb_pkg::*;
#(
  parameter int NUM_DRIVES = 2,
  parameter int LBA_W      = 32,
  parameter int TIMEOUT_W  = 24
) (
  input  logic                        clk_sys,
  input  logic                        reset,
  input  logic [NUM_DRIVES-1:0]       drv_rd,
  input  logic [NUM_DRIVES-1:0]       drv_wr,
  input  logic [NUM_DRIVES*LBA_W-1:0] drv_lba,
  input  logic [NUM_DRIVES-1:0]       img_mounted,
  input  logic                        img_size_nz,
  input  logic                        img_readonly,
  sd_drive_arbiter_if.master          sd,
  output logic [NUM_DRIVES-1:0]       drv_mounted,
  output logic [NUM_DRIVES-1:0]       drv_protect,
  output logic [NUM_DRIVES-1:0]       drv_done,
  output logic [NUM_DRIVES-1:0]       drv_err,
  output logic                        cpu_wait
);
  localparam int ARB_IDX_W = idx_w(NUM_DRIVES);
  localparam int WD_W      = (TIMEOUT_W > 0) ? TIMEOUT_W : 1;
  localparam logic [WD_W-1:0] WD_LAST = {WD_W{1'b1}} - 1'b1;

  sd_arb_state_t               state;
  logic [ARB_IDX_W-1:0]        gnt, rr_ptr, rr_next;
  logic                        serve_rd;
  logic [WD_W-1:0]             wd_cnt;
  logic [NUM_DRIVES-1:0]       rd_pend, wr_pend, rd_pend_n, wr_pend_n;
  logic [NUM_DRIVES-1:0]       rd_q, wr_q;
  logic [NUM_DRIVES*LBA_W-1:0] lba_q;

  logic [NUM_DRIVES-1:0]       acc_rd, acc_wr, rej, unmount, gnt_oh;
  logic [NUM_DRIVES-1:0]       clr_rd, clr_wr, err_n;
  logic                        ack_g, wd_fire, expire;
  logic [ARB_IDX_W-1:0]        arb_idx;
  logic                        arb_valid;

  assign sd.sd_rd  = rd_q;
  assign sd.sd_wr  = wr_q;
  assign sd.sd_lba = lba_q;

  rr_arbiter #(.N(NUM_DRIVES)) u_rr (
    .req       (rd_pend | wr_pend),
    .ptr       (rr_ptr),
    .gnt_idx   (arb_idx),
    .gnt_valid (arb_valid)
  );

  assign wd_fire = (TIMEOUT_W > 0) && (wd_cnt == WD_LAST);
  assign rr_next = (gnt == ARB_IDX_W'(NUM_DRIVES - 1)) ? '0 : gnt + 1'b1;

  // New requests are OR-ed in after every clear so a same-cycle set wins.
  always_comb begin
    ack_g   = sd.sd_ack[gnt];
    gnt_oh  = NUM_DRIVES'(1) << gnt;
    acc_rd  = drv_rd & drv_mounted;
    acc_wr  = drv_wr & drv_mounted & ~drv_protect;
    rej     = (drv_rd & ~drv_mounted) | (drv_wr & (~drv_mounted | drv_protect));
    unmount = img_mounted & drv_mounted & {NUM_DRIVES{~img_size_nz}};
    expire  = wd_fire && ((state == REQ && !ack_g) || (state == XFER && ack_g));
    clr_rd  = unmount;
    clr_wr  = unmount;
    if (state == REQ && ack_g) begin
      if (serve_rd) clr_rd = clr_rd | gnt_oh;
      else          clr_wr = clr_wr | gnt_oh;
    end
    if (expire) begin
      clr_rd = clr_rd | gnt_oh;
      clr_wr = clr_wr | gnt_oh;
    end
    rd_pend_n = (rd_pend & ~clr_rd) | acc_rd;
    wr_pend_n = (wr_pend & ~clr_wr) | acc_wr;
    err_n     = rej | unmount | (expire ? gnt_oh : '0);
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state       <= IDLE;
      gnt         <= '0;
      rr_ptr      <= '0;
      serve_rd    <= 1'b0;
      wd_cnt      <= '0;
      rd_pend     <= '0;
      wr_pend     <= '0;
      rd_q        <= '0;
      wr_q        <= '0;
      lba_q       <= '0;
      drv_mounted <= '0;
      drv_protect <= '0;
      drv_done    <= '0;
      drv_err     <= '0;
      cpu_wait    <= 1'b0;
    end else begin
      rd_pend  <= rd_pend_n;
      wr_pend  <= wr_pend_n;
      drv_err  <= err_n;
      drv_done <= '0;
      cpu_wait <= (state != IDLE) || (|(rd_pend | wr_pend));
      for (int i = 0; i < NUM_DRIVES; i++) begin
        if (img_mounted[i]) begin
          drv_mounted[i] <= img_size_nz;
          drv_protect[i] <= img_readonly;
        end
      end

      case (state)
        IDLE: begin
          if (arb_valid) begin
            gnt      <= arb_idx;
            serve_rd <= rd_pend[arb_idx];
            lba_q[int'(arb_idx)*LBA_W +: LBA_W] <= drv_lba[int'(arb_idx)*LBA_W +: LBA_W];
            if (rd_pend[arb_idx]) rd_q[arb_idx] <= 1'b1;
            else                  wr_q[arb_idx] <= 1'b1;
            wd_cnt   <= '0;
            state    <= REQ;
          end
        end
        REQ: begin
          if (ack_g) begin
            rd_q   <= '0;
            wr_q   <= '0;
            wd_cnt <= '0;
            state  <= XFER;
          end else if (expire) begin
            rd_q   <= '0;
            wr_q   <= '0;
            rr_ptr <= rr_next;
            state  <= IDLE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        XFER: begin
          if (!ack_g) begin
            drv_done[gnt] <= 1'b1;
            rr_ptr        <= rr_next;
            state         <= IDLE;
          end else if (expire) begin
            rr_ptr <= rr_next;
            state  <= IDLE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_drive_arbiter.sv
// tb/tb_sd_drive_arbiter.sv - directed self-checking bench for sd_drive_arbiter
module tb_sd_drive_arbiter;
  import sd_arb_pkg::*;

  localparam int N  = 2;
  localparam int LW = 32;

  logic          clk_sys = 1'b0;
  logic          reset;
  logic [N-1:0]  drv_rd, drv_wr, img_mounted;
  logic [N*LW-1:0] drv_lba;
  logic          img_size_nz, img_readonly;
  logic [N-1:0]  drv_mounted, drv_protect, drv_done, drv_err;
  logic          cpu_wait;
  int            pass_cnt = 0;
  int            total    = 0;

  sd_drive_arbiter_if #(.NUM_DRIVES(N), .LBA_W(LW)) sd_bus ();

  sd_drive_arbiter #(.NUM_DRIVES(N), .LBA_W(LW), .TIMEOUT_W(4)) dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .drv_rd       (drv_rd),
    .drv_wr       (drv_wr),
    .drv_lba      (drv_lba),
    .img_mounted  (img_mounted),
    .img_size_nz  (img_size_nz),
    .img_readonly (img_readonly),
    .sd           (sd_bus.master),
    .drv_mounted  (drv_mounted),
    .drv_protect  (drv_protect),
    .drv_done     (drv_done),
    .drv_err      (drv_err),
    .cpu_wait     (cpu_wait)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic mount(input logic [N-1:0] m, input logic nz, input logic ro);
    img_mounted = m; img_size_nz = nz; img_readonly = ro;
    tick();
    img_mounted = '0; img_size_nz = 1'b0; img_readonly = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b0; drv_rd = '0; drv_wr = '0; drv_lba = '0;
    img_mounted = '0; img_size_nz = 1'b0; img_readonly = 1'b0;
    sd_bus.sd_ack = '0;
    #2;
    do_reset();
    chk("reset_rd",   64'(sd_bus.sd_rd), 64'h0);
    chk("reset_wr",   64'(sd_bus.sd_wr), 64'h0);
    chk("reset_wait", 64'(cpu_wait), 64'h0);
    chk("reset_mnt",  64'(drv_mounted), 64'h0);

    // single read on drive 0
    mount(2'b01, 1'b1, 1'b0);
    chk("mount0", 64'(drv_mounted), 64'h1);
    drv_lba[31:0] = 32'h1234; drv_rd = 2'b01;
    tick(); drv_rd = '0;
    chk("latch_no_grant", 64'(sd_bus.sd_rd), 64'h0);
    tick();
    chk("grant_rd0", 64'(sd_bus.sd_rd), 64'h1);
    chk("grant_lba0", 64'(sd_bus.sd_lba[31:0]), 64'h1234);
    chk("wait_up", 64'(cpu_wait), 64'h1);
    sd_bus.sd_ack = 2'b01; tick();
    chk("ack_drop_rd", 64'(sd_bus.sd_rd), 64'h0);
    tick(2);
    chk("no_done_yet", 64'(drv_done), 64'h0);
    sd_bus.sd_ack = 2'b00; tick();
    chk("done0", 64'(drv_done), 64'h1);
    chk("wait_hold", 64'(cpu_wait), 64'h1);
    tick();
    chk("done0_once", 64'(drv_done), 64'h0);
    chk("wait_down", 64'(cpu_wait), 64'h0);

    // write to readonly drive 1 is rejected
    mount(2'b10, 1'b1, 1'b1);
    chk("mount1_ro", 64'(drv_protect), 64'h2);
    drv_wr = 2'b10; tick(); drv_wr = '0;
    chk("ro_err", 64'(drv_err), 64'h2);
    chk("ro_no_wr", 64'(sd_bus.sd_wr), 64'h0);
    tick();
    chk("ro_err_once", 64'(drv_err), 64'h0);
    chk("ro_no_wait", 64'(cpu_wait), 64'h0);
    chk("ro_no_wr2", 64'(sd_bus.sd_wr), 64'h0);

    // read and write together: read first, then a second grant for the write
    drv_rd = 2'b01; drv_wr = 2'b01; tick(); drv_rd = '0; drv_wr = '0;
    tick();
    chk("rw_rd_first", 64'(sd_bus.sd_rd), 64'h1);
    chk("rw_wr_wait",  64'(sd_bus.sd_wr), 64'h0);
    sd_bus.sd_ack = 2'b01; tick();
    sd_bus.sd_ack = 2'b00; tick();
    chk("rw_done_rd", 64'(drv_done), 64'h1);
    tick();
    chk("rw_wr_second", 64'(sd_bus.sd_wr), 64'h1);
    chk("rw_rd_clear",  64'(sd_bus.sd_rd), 64'h0);
    sd_bus.sd_ack = 2'b01; tick();
    sd_bus.sd_ack = 2'b00; tick();
    chk("rw_done_wr", 64'(drv_done), 64'h1);
    tick(2);
    chk("rw_idle", 64'(cpu_wait), 64'h0);

    // round-robin: both drives at once from rr_ptr=0, third request on drive 0
    do_reset();
    mount(2'b11, 1'b1, 1'b0);
    drv_lba = {32'h0000_00B1, 32'h0000_00A0};
    drv_rd = 2'b11; tick(); drv_rd = '0;
    tick();
    chk("rr_first0", 64'(sd_bus.sd_rd), 64'h1);
    chk("rr_lba_a0", 64'(sd_bus.sd_lba[31:0]), 64'hA0);
    sd_bus.sd_ack = 2'b01; tick();
    drv_lba[31:0] = 32'hC0; drv_rd = 2'b01; tick(); drv_rd = '0;
    sd_bus.sd_ack = 2'b00; tick();
    chk("rr_done0", 64'(drv_done), 64'h1);
    tick();
    chk("rr_then1", 64'(sd_bus.sd_rd), 64'h2);
    chk("rr_lba_b1", 64'(sd_bus.sd_lba[63:32]), 64'hB1);
    sd_bus.sd_ack = 2'b10; tick();
    sd_bus.sd_ack = 2'b00; tick();
    chk("rr_done1", 64'(drv_done), 64'h2);
    tick();
    chk("rr_third0", 64'(sd_bus.sd_rd), 64'h1);
    chk("rr_lba_c0", 64'(sd_bus.sd_lba[31:0]), 64'hC0);
    sd_bus.sd_ack = 2'b01; tick();
    sd_bus.sd_ack = 2'b00; tick();
    chk("rr_done0b", 64'(drv_done), 64'h1);
    tick(2);

    // watchdog: ack never comes
    drv_rd = 2'b01; tick(); drv_rd = '0;
    tick();
    chk("wd_grant", 64'(sd_bus.sd_rd), 64'h1);
    tick(14);
    chk("wd_not_yet", 64'(drv_err), 64'h0);
    chk("wd_rd_held", 64'(sd_bus.sd_rd), 64'h1);
    tick();
    chk("wd_err", 64'(drv_err), 64'h1);
    chk("wd_rd_drop", 64'(sd_bus.sd_rd), 64'h0);
    chk("wd_idle", 64'(dut.state), 64'(IDLE));
    tick();
    chk("wd_err_once", 64'(drv_err), 64'h0);
    chk("wd_wait_down", 64'(cpu_wait), 64'h0);

    // reset mid-transfer with ack held high
    drv_rd = 2'b01; tick(); drv_rd = '0;
    tick();
    sd_bus.sd_ack = 2'b01; tick();
    chk("pre_rst_xfer", 64'(dut.state), 64'(XFER));
    reset = 1'b1; tick(); reset = 1'b0;
    chk("rst_rd",   64'(sd_bus.sd_rd), 64'h0);
    chk("rst_lba",  sd_bus.sd_lba, 64'h0);
    chk("rst_mnt",  64'(drv_mounted), 64'h0);
    chk("rst_wait", 64'(cpu_wait), 64'h0);
    tick();
    sd_bus.sd_ack = 2'b00; tick();
    chk("rst_no_done", 64'(drv_done), 64'h0);
    tick();
    chk("rst_no_done2", 64'(drv_done), 64'h0);
    chk("rst_idle_wait", 64'(cpu_wait), 64'h0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
